player_hp_controller: RTL and testbench

- Downstream consumer of the per-frame damage calculator. Accumulates its damage/heal result into the player's HP.
- Enforces post-hit invulnerability frames, detects death, and supports restart.
- Outputs drive the HP bar renderer and the game-state controller.

---
 rtl/game_pkg.sv | 15 +
 rtl/player_hp_if.sv | 25 ++
 rtl/hp_saturating_alu.sv | 33 +++
 rtl/player_hp_controller.sv | 108 ++++++++++
 tb/tb_player_hp_controller.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared game constants and the player HP state encoding, also used by the HP bar renderer.
package game_pkg;

  localparam int HP_W          = 8;
  localparam int MAX_HP        = 100;
  localparam int HEAL_AMOUNT   = 20;
  localparam int INVULN_FRAMES = 30;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } hp_state_t;

endpackage

// File: rtl/player_hp_if.sv
// Frame-result inputs from the damage calculator and HP status outputs toward renderer/game-state logic.
interface player_hp_if #(
  parameter int HP_W = game_pkg::HP_W
);
  logic [HP_W-1:0] damage;
  logic            heal;
  logic            isComplete;
  logic            frameTick;
  logic            restart;
  logic [HP_W-1:0] hp;
  logic            isInvuln;
  logic            isDead;
  logic            hitPulse;
  logic            gameOver;

  modport master (
    output damage, heal, isComplete, frameTick, restart,
    input  hp, isInvuln, isDead, hitPulse, gameOver
  );

  modport slave (
    input  damage, heal, isComplete, frameTick, restart,
    output hp, isInvuln, isDead, hitPulse, gameOver
  );
endinterface

// File: rtl/hp_saturating_alu.sv
// Combinational HP update: saturating subtract of damage, then optional heal clamped at max_hp.
module hp_saturating_alu #(
  parameter int HP_W = game_pkg::HP_W
) (
  input  logic [HP_W-1:0] hp,
  input  logic [HP_W-1:0] damage,
  input  logic            heal_en,
  input  logic [HP_W-1:0] heal_amount,
  input  logic [HP_W-1:0] max_hp,
  output logic [HP_W-1:0] new_hp,
  output logic            zero_flag
);

  logic [HP_W:0]   diff;
  logic [HP_W-1:0] dmg_hp;
  logic [HP_W:0]   sum;

  // NOTE: every output gets a value on every path through always_comb, otherwise a latch is inferred.
  always_comb begin
    diff   = {1'b0, hp} - {1'b0, damage};
    // The extra MSB is the borrow: damage exceeded hp, so floor at zero instead of wrapping.
    dmg_hp = diff[HP_W] ? '0 : diff[HP_W-1:0];
    sum    = {1'b0, dmg_hp} + {1'b0, heal_amount};
    if (!heal_en)
      new_hp = dmg_hp;
    else if (sum > {1'b0, max_hp})
      new_hp = max_hp;
    else
      new_hp = sum[HP_W-1:0];
    zero_flag = (dmg_hp == '0);
  end

endmodule

// File: rtl/player_hp_controller.sv
// Player HP accumulator with post-hit invulnerability frames, death detection and restart.
module player_hp_controller #(
  parameter int HP_W          = game_pkg::HP_W,
  parameter int MAX_HP        = game_pkg::MAX_HP,
  parameter int HEAL_AMOUNT   = game_pkg::HEAL_AMOUNT,
  parameter int INVULN_FRAMES = game_pkg::INVULN_FRAMES
) (
  input logic       clk,
  input logic       rst_n,
  player_hp_if.slave bus
);

  // Sized so INVULN_FRAMES itself fits, and never zero width when INVULN_FRAMES is 0.
  localparam int CNT_W = $clog2(INVULN_FRAMES + 2);

  game_pkg::hp_state_t state;
  logic [HP_W-1:0]     hp_q;
  logic [CNT_W-1:0]    cnt;
  logic                hit_q;
  logic                over_q;

  logic [HP_W-1:0]     alu_damage;
  logic [HP_W-1:0]     new_hp;
  logic                zero_flag;
  logic                hit;

  // Damage only counts in ALIVE; in INVULN the ALU sees zero damage so only the heal path acts.
  assign alu_damage = (state == game_pkg::ALIVE) ? bus.damage : '0;
  assign hit        = (bus.damage != '0);

  hp_saturating_alu #(.HP_W(HP_W)) u_alu (
    .hp         (hp_q),
    .damage     (alu_damage),
    .heal_en    (bus.heal),
    .heal_amount(HP_W'(HEAL_AMOUNT)),
    .max_hp     (HP_W'(MAX_HP)),
    .new_hp     (new_hp),
    .zero_flag  (zero_flag)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= game_pkg::ALIVE;
      hp_q   <= HP_W'(MAX_HP);
      cnt    <= '0;
      hit_q  <= 1'b0;
      over_q <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      over_q <= 1'b0;
      if (bus.restart) begin
        state <= game_pkg::ALIVE;
        hp_q  <= HP_W'(MAX_HP);
        cnt   <= '0;
      end else begin
        unique case (state)
          game_pkg::ALIVE: begin
            // A frameTick here is deliberately ignored, so a fresh hit keeps its full count.
            if (bus.isComplete) begin
              if (hit && zero_flag) begin
                state  <= game_pkg::DEAD;
                hp_q   <= '0;
                hit_q  <= 1'b1;
                over_q <= 1'b1;
              end else begin
                hp_q <= new_hp;
                if (hit) begin
                  hit_q <= 1'b1;
                  if (INVULN_FRAMES != 0) begin
                    state <= game_pkg::INVULN;
                    cnt   <= CNT_W'(INVULN_FRAMES);
                  end
                end
              end
            end
          end
          game_pkg::INVULN: begin
            if (bus.isComplete)
              hp_q <= new_hp;
            if (bus.frameTick) begin
              if (cnt > CNT_W'(1)) begin
                cnt <= cnt - 1'b1;
              end else begin
                cnt   <= '0;
                state <= game_pkg::ALIVE;
              end
            end
          end
          game_pkg::DEAD: begin
            hp_q <= '0;
          end
          default: begin
            state <= game_pkg::ALIVE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.hp       = hp_q;
  assign bus.isInvuln = (state == game_pkg::INVULN);
  assign bus.isDead   = (state == game_pkg::DEAD);
  assign bus.hitPulse = hit_q;
  assign bus.gameOver = over_q;

endmodule

// File: tb/tb_player_hp_controller.sv
// Directed scenario bench for player_hp_controller with hand-computed expected values.
module tb_player_hp_controller;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  player_hp_if #(.HP_W(8)) bus ();

  player_hp_controller dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus: inputs set, edge taken, outputs sampled 1 ns later, pulses cleared.
  task automatic drive(input logic c, input logic [7:0] d, input logic h,
                       input logic t, input logic r);
    bus.isComplete = c;
    bus.damage     = d;
    bus.heal       = h;
    bus.frameTick  = t;
    bus.restart    = r;
    @(posedge clk);
    #1;
    bus.isComplete = 1'b0;
    bus.damage     = '0;
    bus.heal       = 1'b0;
    bus.frameTick  = 1'b0;
    bus.restart    = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.hp !== 8'd100) begin errors++; $display("FAIL reset_hp: got %0d expected 100", bus.hp); end
    checks++; if ({bus.isInvuln, bus.isDead, bus.hitPulse, bus.gameOver} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {bus.isInvuln, bus.isDead, bus.hitPulse, bus.gameOver}); end
    #3 rst_n = 1'b1;
    drive(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.hp !== 8'd100) begin errors++; $display("FAIL nop_hp: got %0d expected 100", bus.hp); end
    checks++; if ({bus.isInvuln, bus.isDead, bus.hitPulse, bus.gameOver} !== 4'b0000) begin errors++; $display("FAIL nop_flags: got %b expected 0000", {bus.isInvuln, bus.isDead, bus.hitPulse, bus.gameOver}); end
  endtask

  task automatic test_hit_invuln();
    drive(1'b1, 8'd30, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.hp !== 8'd70) begin errors++; $display("FAIL hit_hp: got %0d expected 70", bus.hp); end
    checks++; if ({bus.hitPulse, bus.isInvuln} !== 2'b11) begin errors++; $display("FAIL hit_flags: got %b expected 11", {bus.hitPulse, bus.isInvuln}); end
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.hitPulse !== 1'b0) begin errors++; $display("FAIL hit_one_cycle: got %b expected 0", bus.hitPulse); end
    ticks(14);
    drive(1'b1, 8'd10, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.hp !== 8'd70) begin errors++; $display("FAIL invuln_ignore_hp: got %0d expected 70", bus.hp); end
    checks++; if ({bus.hitPulse, bus.isInvuln} !== 2'b01) begin errors++; $display("FAIL invuln_ignore_flags: got %b expected 01", {bus.hitPulse, bus.isInvuln}); end
    ticks(14);
    checks++; if (bus.isInvuln !== 1'b1) begin errors++; $display("FAIL invuln_29_ticks: got %b expected 1", bus.isInvuln); end
    ticks(1);
    checks++; if (bus.isInvuln !== 1'b0) begin errors++; $display("FAIL invuln_30_ticks: got %b expected 0", bus.isInvuln); end
  endtask

  task automatic test_heal();
    drive(1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.hp !== 8'd90) begin errors++; $display("FAIL heal_70: got %0d expected 90", bus.hp); end
    drive(1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.hp !== 8'd100) begin errors++; $display("FAIL heal_clamp: got %0d expected 100", bus.hp); end
    checks++; if (bus.hitPulse !== 1'b0) begin errors++; $display("FAIL heal_no_hit: got %b expected 0", bus.hitPulse); end
    drive(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.hp !== 8'd95) begin errors++; $display("FAIL small_hit: got %0d expected 95", bus.hp); end
    drive(1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.hp !== 8'd100) begin errors++; $display("FAIL invuln_heal_hp: got %0d expected 100", bus.hp); end
    checks++; if ({bus.hitPulse, bus.isInvuln} !== 2'b01) begin errors++; $display("FAIL invuln_heal_flags: got %b expected 01", {bus.hitPulse, bus.isInvuln}); end
    ticks(30);
    drive(1'b1, 8'd30, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.hp !== 8'd90) begin errors++; $display("FAIL hit_plus_heal: got %0d expected 90", bus.hp); end
    checks++; if ({bus.hitPulse, bus.isInvuln} !== 2'b11) begin errors++; $display("FAIL hit_plus_heal_flags: got %b expected 11", {bus.hitPulse, bus.isInvuln}); end
    ticks(30);
  endtask

  task automatic test_death();
    drive(1'b1, 8'd70, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.hp !== 8'd20) begin errors++; $display("FAIL to_20: got %0d expected 20", bus.hp); end
    ticks(30);
    drive(1'b1, 8'd40, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.hp !== 8'd0) begin errors++; $display("FAIL death_hp: got %0d expected 0", bus.hp); end
    checks++; if ({bus.isDead, bus.gameOver, bus.hitPulse, bus.isInvuln} !== 4'b1110) begin errors++; $display("FAIL death_flags: got %b expected 1110", {bus.isDead, bus.gameOver, bus.hitPulse, bus.isInvuln}); end
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    checks++; if ({bus.isDead, bus.gameOver, bus.hitPulse} !== 3'b100) begin errors++; $display("FAIL death_one_pulse: got %b expected 100", {bus.isDead, bus.gameOver, bus.hitPulse}); end
    drive(1'b1, 8'd50, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.hp !== 8'd0) begin errors++; $display("FAIL dead_hold_hp: got %0d expected 0", bus.hp); end
    checks++; if ({bus.isDead, bus.gameOver, bus.hitPulse} !== 3'b100) begin errors++; $display("FAIL dead_hold_flags: got %b expected 100", {bus.isDead, bus.gameOver, bus.hitPulse}); end
  endtask

  task automatic test_restart();
    drive(1'b1, 8'd10, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.hp !== 8'd100) begin errors++; $display("FAIL restart_hp: got %0d expected 100", bus.hp); end
    checks++; if ({bus.isInvuln, bus.isDead, bus.hitPulse, bus.gameOver} !== 4'b0000) begin errors++; $display("FAIL restart_flags: got %b expected 0000", {bus.isInvuln, bus.isDead, bus.hitPulse, bus.gameOver}); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
    ticks(18);
    checks++; if ({bus.hp, bus.isInvuln} !== {8'd90, 1'b1}) begin errors++; $display("FAIL pre_reset: got hp=%0d inv=%b expected hp=90 inv=1", bus.hp, bus.isInvuln); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({bus.hp, bus.isInvuln} !== {8'd100, 1'b0}) begin errors++; $display("FAIL async_reset: got hp=%0d inv=%b expected hp=100 inv=0", bus.hp, bus.isInvuln); end
    #2 rst_n = 1'b1;
    drive(1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
    ticks(29);
    checks++; if (bus.isInvuln !== 1'b1) begin errors++; $display("FAIL reload_29: got %b expected 1", bus.isInvuln); end
    drive(1'b1, 8'd40, 1'b0, 1'b1, 1'b0);
    checks++; if ({bus.hp, bus.isInvuln, bus.hitPulse} !== {8'd90, 1'b0, 1'b0}) begin errors++; $display("FAIL expire_with_dmg: got hp=%0d inv=%b hit=%b expected hp=90 inv=0 hit=0", bus.hp, bus.isInvuln, bus.hitPulse); end
    drive(1'b1, 8'd40, 1'b0, 1'b1, 1'b0);
    checks++; if ({bus.hp, bus.isInvuln, bus.hitPulse} !== {8'd50, 1'b1, 1'b1}) begin errors++; $display("FAIL alive_hit_tick: got hp=%0d inv=%b hit=%b expected hp=50 inv=1 hit=1", bus.hp, bus.isInvuln, bus.hitPulse); end
    ticks(29);
    checks++; if (bus.isInvuln !== 1'b1) begin errors++; $display("FAIL full_count_29: got %b expected 1", bus.isInvuln); end
    ticks(1);
    checks++; if (bus.isInvuln !== 1'b0) begin errors++; $display("FAIL full_count_30: got %b expected 0", bus.isInvuln); end
  endtask

  task automatic test_saturation();
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
    checks++; if ({bus.hp, bus.isDead, bus.gameOver} !== {8'd0, 1'b1, 1'b1}) begin errors++; $display("FAIL dmg_all_ones: got hp=%0d dead=%b go=%b expected hp=0 dead=1 go=1", bus.hp, bus.isDead, bus.gameOver); end
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'd101, 1'b1, 1'b0, 1'b0);
    checks++; if ({bus.hp, bus.isDead} !== {8'd0, 1'b1}) begin errors++; $display("FAIL dmg_over_max: got hp=%0d dead=%b expected hp=0 dead=1", bus.hp, bus.isDead); end
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'd99, 1'b0, 1'b0, 1'b0);
    checks++; if ({bus.hp, bus.isDead, bus.isInvuln} !== {8'd1, 1'b0, 1'b1}) begin errors++; $display("FAIL dmg_to_one: got hp=%0d dead=%b inv=%b expected hp=1 dead=0 inv=1", bus.hp, bus.isDead, bus.isInvuln); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.isComplete = 1'b0;
    bus.damage     = '0;
    bus.heal       = 1'b0;
    bus.frameTick  = 1'b0;
    bus.restart    = 1'b0;
    test_reset();
    test_hit_invuln();
    test_heal();
    test_death();
    test_restart();
    test_async_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
